line_buffer_32: RTL and testbench

//   Single image-line store for the sliding-window front end. Holds one line of

---
 rtl/line_buffer_32_pkg.sv | 11 +
 rtl/line_buffer_32.sv | 65 ++++++
 tb/tb_line_buffer_32.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/line_buffer_32_pkg.sv
// Shared sizing for the sliding-window line buffers of the Harris corner pipeline.
// Pixel width follows the pipeline operand size (opsize + 1).
package line_buffer_32_pkg;

  localparam int LB_OPSIZE   = 15;
  localparam int LB_DATA_W   = LB_OPSIZE + 1;
  localparam int LB_LINE_LEN = 512;
  localparam int LB_PTR_W    = $clog2(LB_LINE_LEN);
  localparam int LB_TAPS     = 3;

endpackage : line_buffer_32_pkg

// File: rtl/line_buffer_32.sv
// One image line of pixels with independent write and read pointers; presents a
// 1x3 row slice at the read pointer through three combinational read ports.
module line_buffer_32
  import line_buffer_32_pkg::*;
#(
  parameter int DATA_W   = LB_DATA_W,
  parameter int LINE_LEN = LB_LINE_LEN,
  parameter int PTR_W    = $clog2(LINE_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic              i_rd_data,
  output logic [DATA_W-1:0] o_data [0:LB_TAPS-1]
);

  logic [DATA_W-1:0] mem_q [0:LINE_LEN-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              wr_en_s;

  // Next-state pointers; PTR_W-bit addition gives the line wrap for free.
  always_comb begin
    wr_en_s  = i_data_valid & i_rst;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_data_valid) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (i_rd_data) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; pixel storage is deliberately left out of reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Pixel store; no reset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Row slice taps; no write bypass, so a same-cycle write shows after the edge.
  always_comb begin
    for (int k = 0; k < LB_TAPS; k++) begin
      o_data[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

endmodule : line_buffer_32

// File: tb/tb_line_buffer_32.sv
// Randomised bench for line_buffer_32 against an array/modulo reference model
// of one image line with independent write and read positions.
module tb_line_buffer_32;

  localparam int DW  = 16;
  localparam int LEN = 512;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          i_rd_data;
  logic [DW-1:0] o_data [0:2];

  int n_checks;
  int n_errors;

  int         ref_mem [0:LEN-1];
  bit         ref_known [0:LEN-1];
  int         ref_wr;
  int         ref_rd;
  int         hold_val;

  line_buffer_32 dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // compare all three taps against the model wherever the model knows the pixel
  task automatic check_out(input string tag);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ref_rd + k) % LEN;
      if (ref_known[idx]) check_val($sformatf("%s_tap%0d", tag, k), int'(o_data[k]), ref_mem[idx]);
    end
  endtask

  // one clock: drive at posedge+1, optional pre-edge check, model update, post-edge check
  task automatic step(input bit v, input int d, input bit r, input bit pre);
    i_data_valid = v;
    i_data       = DW'(d);
    i_rd_data    = r;
    #2;
    if (pre) check_out("pre");
    @(posedge clk);
    if (rst_n) begin
      if (v) begin
        ref_mem[ref_wr]   = d & 16'hFFFF;
        ref_known[ref_wr] = 1'b1;
        ref_wr            = (ref_wr + 1) % LEN;
      end
      if (r) ref_rd = (ref_rd + 1) % LEN;
    end
    #1;
    check_out("post");
  endtask

  task automatic check_slice(input string tag, input int e0, input int e1, input int e2);
    check_val({tag, "_0"}, int'(o_data[0]), e0);
    check_val({tag, "_1"}, int'(o_data[1]), e1);
    check_val({tag, "_2"}, int'(o_data[2]), e2);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ref_wr = 0;
    ref_rd = 0;
    for (int i = 0; i < LEN; i++) begin
      ref_mem[i]   = 0;
      ref_known[i] = 1'b0;
    end
    rst_n        = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // fill the line with pixel = index, no reads
    for (int i = 0; i < LEN; i++) step(1'b1, i, 1'b0, 1'b0);
    check_slice("fill", 0, 1, 2);

    // ten read pulses with random gaps; gaps must hold the slice
    for (int i = 0; i < 10; i++) begin
      step(1'b0, int'($urandom_range(0, 65535)), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b0, 0, 1'b0, 1'b0);
    end
    check_slice("rd10", 10, 11, 12);

    // advance to the end-of-line wrap points
    repeat (500) step(1'b0, 0, 1'b1, 1'b0);
    check_slice("rd510", 510, 511, 0);
    step(1'b0, 0, 1'b1, 1'b0);
    check_slice("rd511", 511, 0, 1);
    step(1'b0, 0, 1'b1, 1'b0);
    check_slice("rdwrap", 0, 1, 2);

    // overwrite behind the read pointer: old value during the write cycle, new after
    for (int i = 0; i < LEN; i++) begin
      hold_val = ref_mem[ref_rd];
      i_data_valid = 1'b1;
      i_data       = DW'(1000 + i);
      i_rd_data    = 1'b0;
      #2;
      check_val("samecyc_old", int'(o_data[0]), hold_val);
      step(1'b1, 1000 + i, 1'b0, 1'b0);
      check_val("samecyc_new", int'(o_data[0]), 1000 + i);
      step(1'b0, 0, 1'b1, 1'b0);
    end

    // strobe low with data toggling: nothing stored, write pointer frozen
    for (int i = 0; i < 20; i++) step(1'b0, (i % 2) ? 16'hFFFF : 16'h0000, 1'b0, 1'b1);
    check_slice("idle", 1000, 1001, 1002);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check_val("resume_wr", int'(o_data[0]), 16'hBEEF);

    // random traffic with both pointers free-running
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b1);

    // asynchronous reset mid-stream, away from any clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    ref_wr = 0;
    ref_rd = 0;
    #1;
    check_out("async_rst");
    for (int i = 0; i < 3; i++) step(1'b1, int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    check_out("in_rst");
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check_val("post_rst_wr", int'(o_data[0]), 16'h1234);

    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_line_buffer_32
